// File: rtl/od_io_pkg.sv
// Shared definitions for the open-drain pin I/O blocks: button debouncer state
// encoding and board-level timing defaults.
package od_io_pkg;

    typedef enum logic [1:0] {
        StReleased   = 2'd0,
        StPressChk   = 2'd1,
        StHeld       = 2'd2,
        StReleaseChk = 2'd3
    } btn_state_t;

    localparam int unsigned CLK_HZ      = 12000000;
    localparam int unsigned DEBOUNCE_MS = 10;
    localparam int unsigned LONG_MS     = 1000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            q      <= RESET_VAL;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/od_button_debouncer.sv
// Debounces an active-low open-drain button input and produces a clean level,
// press/release/long-press pulses and an LED open-drain enable.
module od_button_debouncer
    import od_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS,
    parameter int unsigned LONG_CYCLES     = CLK_HZ / 1000 * LONG_MS,
    parameter int unsigned CNT_W           = $clog2(LONG_CYCLES + 1)
) (
    input  logic CLK,
    input  logic RST,
    input  logic button_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic led_oe
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             s;
    btn_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             fired;
    logic             press_evt;
    logic             rel_evt;
    logic             long_evt;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (CLK),
        .rst (RST),
        .d   (button_n),
        .q   (s)
    );

    // Events are flagged on the transition edge and presented one cycle later
    // together with the level, so pressed and its pulses always line up.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= StReleased;
            cnt           <= '0;
            fired         <= 1'b0;
            press_evt     <= 1'b0;
            rel_evt       <= 1'b0;
            long_evt      <= 1'b0;
            pressed       <= 1'b0;
            led_oe        <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            press_evt     <= 1'b0;
            rel_evt       <= 1'b0;
            long_evt      <= 1'b0;
            pressed       <= (state == StHeld) || (state == StReleaseChk);
            led_oe        <= (state == StHeld) || (state == StReleaseChk);
            press_pulse   <= press_evt;
            release_pulse <= rel_evt;
            long_pulse    <= long_evt;

            unique case (state)
                StReleased: begin
                    fired <= 1'b0;
                    if (!s) begin
                        state <= StPressChk;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                StPressChk: begin
                    if (s) begin
                        state <= StReleased;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state     <= StHeld;
                        cnt       <= '0;
                        press_evt <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                StHeld: begin
                    if (s) begin
                        state <= StReleaseChk;
                        cnt   <= CNT_ONE;
                    end else begin
                        if (cnt != LONG_MAX) begin
                            cnt <= cnt + CNT_ONE;
                        end
                        // fired survives release glitches so one hold gives one long_pulse
                        if (cnt == LONG_LAST && !fired) begin
                            long_evt <= 1'b1;
                            fired    <= 1'b1;
                        end
                    end
                end
                StReleaseChk: begin
                    if (!s) begin
                        state <= StHeld;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state   <= StReleased;
                        cnt     <= '0;
                        rel_evt <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= StReleased;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/od_button_debouncer.md
Name: od_button_debouncer

Overview:
- Input-side companion to the open-drain LED output path on the iCEBreaker.
- Takes the raw active-low button level from an input-only SB_IO_OD (DIN0), synchronises it, and debounces it with a four-state machine.
- Produces a clean pressed level, single-cycle press, release and long-press events, and an open-drain enable that sinks the LED cathode while the button is held.
- Sits between the button pin primitive and user logic or the LED SB_IO_OD.

Parameters:
- DEBOUNCE_CYCLES, 120000, consecutive stable cycles required to accept a level change (10 ms at 12 MHz); must be >= 2.
- LONG_CYCLES, 12000000, cycles held after debounced press before long_pulse fires (1 s at 12 MHz); must be > DEBOUNCE_CYCLES.
- CNT_W, $clog2(LONG_CYCLES+1), shared counter width (derived; do not override).

Ports:
- CLK  input  1  system clock (12 MHz board oscillator)
- RST  input  1  asynchronous, active-high reset
- button_n  input  1  raw button level from SB_IO_OD DIN0; 0 = pressed, 1 = released (pulled up)
- pressed  output  1  debounced level, 1 while button accepted as held
- press_pulse  output  1  one-cycle pulse on accepted press
- release_pulse  output  1  one-cycle pulse on accepted release
- long_pulse  output  1  one-cycle pulse when held for LONG_CYCLES
- led_oe  output  1  open-drain enable for LED cathode; equals pressed

Behaviour:
- Reset (async assert, sync release):
  - sync FFs = 1; state = RELEASED; counter = 0.
  - All outputs = 0.
- Synchroniser: 2-FF chain on button_n; only sync2 (s) feeds logic. All other logic is fully synchronous to CLK.
- States and transitions:
  - RELEASED: if s=0, go to PRESS_CHK with cnt=1; else cnt=0.
  - PRESS_CHK:
    - If s=1, return to RELEASED with cnt=0 (bounce rejected, no pulse).
    - Else if cnt=DEBOUNCE_CYCLES-1, go to HELD, cnt=0, press_pulse=1 next cycle.
    - Else cnt+1.
  - HELD:
    - If s=1, go to RELEASE_CHK with cnt=1 (long counter abandoned).
    - Else cnt increments, saturating at LONG_CYCLES.
    - long_pulse=1 for exactly the cycle after cnt reaches LONG_CYCLES-1. Never repeats within one hold.
  - RELEASE_CHK:
    - If s=0, return to HELD. Long-press count restarts from 0; a long_pulse already fired does not refire, because a fired flag is kept until the next RELEASED.
    - Else if cnt=DEBOUNCE_CYCLES-1, go to RELEASED, cnt=0, release_pulse=1.
    - Else cnt+1.
- pressed = 1 in HELD and RELEASE_CHK; 0 in RELEASED and PRESS_CHK. led_oe is identical.
- All outputs are registered.
- Latency: first low at button_n, held stable, gives press_pulse and pressed rising 2+DEBOUNCE_CYCLES cycles after the sampling edge. Release is symmetric.
- press_pulse and release_pulse are never asserted together.
- long_pulse occurs only while pressed=1, and at most once per press.
- Counter width: cnt never exceeds LONG_CYCLES; no wrap.
- Reset mid-hold: outputs drop to 0 immediately (async); no release_pulse is generated.
- Button held during reset release: press is accepted 2+DEBOUNCE_CYCLES cycles after RST deasserts.

Decomposition:
- Shared package od_io_pkg holds:
  - the state typedef (RELEASED, PRESS_CHK, HELD, RELEASE_CHK; 2-bit encoding);
  - default constants CLK_HZ=12000000, DEBOUNCE_MS=10, LONG_MS=1000.
- One sub-module: sync_2ff (reset value parameter, 1-bit). It is reusable by future pin inputs.
- Counter and FSM stay in the top body.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20):
- Reset with button_n=1 -> all outputs 0. After RST drop, 50 idle cycles -> no pulses.
- button_n 1->0 held 30 cycles -> press_pulse exactly once, 6 cycles after the edge; pressed and led_oe=1 from then on; long_pulse once 20 cycles after press_pulse.
- Bounce: button_n low 3 cycles, high 1, low 2, high -> no pulse, pressed stays 0.
- Hold 10 cycles after press, release with a 2-cycle glitch back low, then stay high -> no release_pulse during glitch, pressed stays 1; release_pulse once 4+2 cycles after final high; long_pulse never fires.
- Hold 25 cycles (long_pulse fires), 2-cycle release glitch, hold 30 more -> long_pulse not repeated.
- RST asserted while pressed=1 -> pressed, led_oe drop in the same cycle; no release_pulse. RST released with button low -> press_pulse 6 cycles later.
